bp_io_reg_endpoint: RTL and testbench

//   I/O-side endpoint that consumes uncached I/O commands (e_cce_mem_uc_rd / e_cce_mem_uc_wr)

---
 rtl/bp_io_reg_endpoint.sv | 208 ++++++++++++++++++++
 tb/tb_bp_io_reg_endpoint.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_io_reg_endpoint.sv
// I/O register endpoint: answers uncached I/O commands from the I/O CCE
// with one response each, backed by a small bank of 64-bit registers.
// Register 0 is a read-only device ID; registers 1..num_regs_p-1 are RW.
//
// Message layout (bp_cce_mem_msg_s, LSB first):
//   msg_type[3:0] | addr[paddr_width_p] | size[2:0] | way_id | lce_id | data[cce_block_width_p]
// cce_block_width_p must be at least 64.
//
// state   | meaning
// --------+---------------------------------------------------------
// e_ready | idle, io_cmd_ready_o high, waiting for a command
// e_resp  | response held on io_resp_o until io_resp_yumi_i
module bp_io_reg_endpoint #(
  parameter int                         paddr_width_p     = 40,
  parameter int                         lce_id_width_p    = 4,
  parameter int                         way_id_width_p    = 3,
  parameter int                         cce_block_width_p = 128,
  parameter int                         num_regs_p        = 8,
  parameter logic [paddr_width_p-1:0]   base_addr_p       = 'h0010_0000,
  parameter logic [63:0]                dev_id_p          = 64'h0,
  localparam int cce_mem_msg_width_lp = 4 + paddr_width_p + 3 + way_id_width_p
                                        + lce_id_width_p + cce_block_width_p
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic [cce_mem_msg_width_lp-1:0] io_cmd_i,
  input  logic                            io_cmd_v_i,
  output logic                            io_cmd_ready_o,
  output logic [cce_mem_msg_width_lp-1:0] io_resp_o,
  output logic                            io_resp_v_o,
  input  logic                            io_resp_yumi_i
);

  localparam logic [3:0] e_cce_mem_uc_rd = 4'd2;
  localparam logic [3:0] e_cce_mem_uc_wr = 4'd3;

  localparam logic [2:0] e_mem_size_1 = 3'd0;
  localparam logic [2:0] e_mem_size_2 = 3'd1;
  localparam logic [2:0] e_mem_size_4 = 3'd2;

  localparam int                       idx_width_lp = $clog2(num_regs_p);
  localparam logic [paddr_width_p-1:0] span_lp      = paddr_width_p'(8 * num_regs_p);

  typedef struct packed {
    logic [lce_id_width_p-1:0] lce_id;
    logic [way_id_width_p-1:0] way_id;
  } payload_s;

  typedef struct packed {
    payload_s                 payload;
    logic [2:0]               size;
    logic [paddr_width_p-1:0] addr;
    logic [3:0]               msg_type;
  } hdr_s;

  typedef struct packed {
    logic [cce_block_width_p-1:0] data;
    hdr_s                         hdr;
  } bp_cce_mem_msg_s;

  typedef enum logic {
    e_ready = 1'b0,
    e_resp  = 1'b1
  } state_e;

  state_e state_q, state_d;

  bp_cce_mem_msg_s cmd_li, resp_lo;

  logic [63:0] regs_q [num_regs_p];
  hdr_s        resp_hdr_q;
  logic [63:0] resp_data_q;

  logic                     accept;
  logic [paddr_width_p-1:0] off;
  logic                     hit;
  logic [idx_width_lp-1:0]  idx;
  logic [2:0]               lane;
  logic [7:0]               size_mask;
  logic                     aligned;
  logic [7:0]               byte_en;
  logic [63:0]              bit_mask;
  logic [63:0]              wdata_shift;
  logic [63:0]              rd_word;
  logic [63:0]              rd_shift;
  logic [63:0]              rd_data;
  logic                     is_rd;
  logic                     is_wr;
  logic                     wr_en;

  // Bits of the command data beyond the 64-bit register width carry no meaning here.
  logic unused_cmd_data;
  assign unused_cmd_data = ^cmd_li.data;

  assign cmd_li    = io_cmd_i;
  assign io_resp_o = resp_lo;
  assign accept    = io_cmd_v_i & io_cmd_ready_o;

  // Address decode, lane alignment and the shifted read/write data paths.
  always_comb begin
    off       = cmd_li.hdr.addr - base_addr_p;
    hit       = (cmd_li.hdr.addr >= base_addr_p) && (off < span_lp);
    idx       = off[3 +: idx_width_lp];
    lane      = cmd_li.hdr.addr[2:0];
    size_mask = 8'hFF;
    aligned   = (lane == 3'd0);
    case (cmd_li.hdr.size)
      e_mem_size_1: begin
        size_mask = 8'h01;
        aligned   = 1'b1;
      end
      e_mem_size_2: begin
        size_mask = 8'h03;
        aligned   = (lane[0] == 1'b0);
      end
      e_mem_size_4: begin
        size_mask = 8'h0F;
        aligned   = (lane[1:0] == 2'd0);
      end
      default: begin
        size_mask = 8'hFF;
        aligned   = (lane == 3'd0);
      end
    endcase

    // Alignment guarantees the lane window never wraps past byte 7.
    byte_en  = size_mask << lane;
    bit_mask = '0;
    for (int b = 0; b < 8; b++) begin
      bit_mask[8*b +: 8] = {8{size_mask[b]}};
    end

    wdata_shift = cmd_li.data[63:0] << {lane, 3'b000};
    rd_word     = (idx == '0) ? dev_id_p : regs_q[idx];
    rd_shift    = rd_word >> {lane, 3'b000};

    is_rd = (cmd_li.hdr.msg_type == e_cce_mem_uc_rd);
    is_wr = (cmd_li.hdr.msg_type == e_cce_mem_uc_wr);

    rd_data = (is_rd && hit && aligned) ? (rd_shift & bit_mask) : 64'h0;
    wr_en   = accept && is_wr && hit && aligned && (idx != '0);
  end

  // Register bank; the ID slot is never written and reads come from dev_id_p.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      for (int r = 0; r < num_regs_p; r++) begin
        regs_q[r] <= '0;
      end
    end else if (wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if (byte_en[b]) begin
          regs_q[idx][8*b +: 8] <= wdata_shift[8*b +: 8];
        end
      end
    end
  end

  // Capture header and read data at accept so the response is immune to later writes.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      resp_hdr_q  <= '0;
      resp_data_q <= '0;
    end else if (accept) begin
      resp_hdr_q  <= cmd_li.hdr;
      resp_data_q <= rd_data;
    end
  end

  // Assemble the response: echoed header, read data zero-extended to the block width.
  always_comb begin
    resp_lo            = '0;
    resp_lo.hdr        = resp_hdr_q;
    resp_lo.data[63:0] = resp_data_q;
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= e_ready;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state and handshake outputs.
  always_comb begin
    state_d        = state_q;
    io_cmd_ready_o = 1'b0;
    io_resp_v_o    = 1'b0;
    case (state_q)
      e_ready: begin
        io_cmd_ready_o = reset_n_i;
        if (io_cmd_v_i && reset_n_i) begin
          state_d = e_resp;
        end
      end
      e_resp: begin
        io_resp_v_o = 1'b1;
        if (io_resp_yumi_i) begin
          state_d = e_ready;
        end
      end
      default: state_d = e_ready;
    endcase
  end

endmodule

// File: tb/tb_bp_io_reg_endpoint.sv
// Scoreboard bench for bp_io_reg_endpoint: driver pushes expected responses
// from a byte-array reference model, monitor compares every valid cycle.
module tb_bp_io_reg_endpoint;

  localparam int          PADDR  = 40;
  localparam int          LCE_W  = 4;
  localparam int          WAY_W  = 3;
  localparam int          BLK    = 128;
  localparam int          NREGS  = 8;
  localparam logic [39:0] BASE   = 40'h0010_0000;
  localparam logic [63:0] DEV_ID = 64'h1234_5678_9ABC_DEF0;
  localparam int          MSG_W  = 4 + PADDR + 3 + WAY_W + LCE_W + BLK;
  localparam int          LCE_LSB  = 4 + PADDR + 3 + WAY_W;
  localparam int          DATA_LSB = LCE_LSB + LCE_W;

  logic             clk;
  logic             reset_n;
  logic [MSG_W-1:0] io_cmd;
  logic             io_cmd_v;
  logic             io_cmd_ready;
  logic [MSG_W-1:0] io_resp;
  logic             io_resp_v;
  logic             io_resp_yumi;

  bp_io_reg_endpoint #(
    .paddr_width_p    (PADDR),
    .lce_id_width_p   (LCE_W),
    .way_id_width_p   (WAY_W),
    .cce_block_width_p(BLK),
    .num_regs_p       (NREGS),
    .base_addr_p      (BASE),
    .dev_id_p         (DEV_ID)
  ) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .io_cmd_i      (io_cmd),
    .io_cmd_v_i    (io_cmd_v),
    .io_cmd_ready_o(io_cmd_ready),
    .io_resp_o     (io_resp),
    .io_resp_v_o   (io_resp_v),
    .io_resp_yumi_i(io_resp_yumi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int cmps  = 0;
  int fails = 0;

  typedef struct {
    logic [MSG_W-1:0] resp;
    int               acc;
  } exp_t;
  exp_t sb_q[$];

  logic [7:0] mdl_mem [NREGS*8];

  int               yumi_mode = 0;   // 0 random, 1 always, 2 never
  logic [MSG_W-1:0] last_resp = '0;
  int               last_yumi = 0;
  int               last_acc  = 0;

  function automatic logic [MSG_W-1:0] pack(input logic [3:0] t, input logic [39:0] a,
                                             input logic [2:0] s, input logic [3:0] l,
                                             input logic [2:0] w, input logic [127:0] d);
    return {d, l, w, s, a, t};
  endfunction

  // Reference model: registers as a flat byte array, addressed by plain arithmetic.
  function automatic logic [63:0] model_apply(input logic [3:0] t, input logic [39:0] a,
                                              input logic [2:0] s, input logic [63:0] wd);
    int          nb, idx, lane;
    logic [63:0] r;
    logic [63:0] id;
    r  = 64'h0;
    id = DEV_ID;
    nb = (s >= 3) ? 8 : (1 << s);
    if (a < BASE || a >= BASE + 40'(8 * NREGS)) return 64'h0;
    idx  = int'((a - BASE) / 8);
    lane = int'(a % 8);
    if ((lane % nb) != 0) return 64'h0;
    if (t == 4'd3) begin
      if (idx != 0)
        for (int b = 0; b < nb; b++) mdl_mem[idx*8 + lane + b] = wd[8*b +: 8];
      return 64'h0;
    end
    if (t != 4'd2) return 64'h0;
    for (int b = 0; b < nb; b++)
      r[8*b +: 8] = (idx == 0) ? id[8*(lane + b) +: 8] : mdl_mem[idx*8 + lane + b];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [MSG_W-1:0] act, input logic [MSG_W-1:0] exp);
    cmps++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic send(input logic [3:0] t, input logic [39:0] a, input logic [2:0] s,
                      input logic [3:0] l, input logic [2:0] w, input logic [127:0] d);
    int          g;
    logic [63:0] rd;
    io_cmd   = pack(t, a, s, l, w, d);
    io_cmd_v = 1'b1;
    g = 0;
    @(negedge clk);
    while (!io_cmd_ready && g < 200) begin
      g++;
      @(negedge clk);
    end
    if (!io_cmd_ready) begin
      cmps++;
      fails++;
      $display("FAIL accept_timeout: ready got 0 expected 1 (cycle %0d)", cyc);
      io_cmd_v = 1'b0;
      return;
    end
    rd = model_apply(t, a, s, d[63:0]);
    sb_q.push_back('{resp: pack(t, a, s, l, w, {64'h0, rd}), acc: cyc});
    last_acc = cyc;
    @(posedge clk);
    #1;
    io_cmd_v = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb_q.size() != 0 && g < 300) begin
      g++;
      @(posedge clk);
    end
    if (sb_q.size() != 0) begin
      cmps++;
      fails++;
      $display("FAIL drain_timeout: pending got %0d expected 0", sb_q.size());
      sb_q.delete();
    end
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: compares the presented response every valid cycle and consumes it.
  initial begin
    bit seen;
    seen = 0;
    io_resp_yumi = 1'b0;
    forever begin
      @(negedge clk);
      if (io_resp_v) begin
        chk("ready_low_in_resp", MSG_W'(io_cmd_ready), MSG_W'(0));
        if (sb_q.size() == 0) begin
          cmps++;
          fails++;
          $display("FAIL unexpected_resp: got %h expected none", io_resp);
          io_resp_yumi = 1'b1;
        end else begin
          if (!seen) begin
            chk("latency", MSG_W'(cyc), MSG_W'(sb_q[0].acc + 1));
            seen = 1;
          end
          chk("resp", io_resp, sb_q[0].resp);
          case (yumi_mode)
            1:       io_resp_yumi = 1'b1;
            2:       io_resp_yumi = 1'b0;
            default: io_resp_yumi = 1'($urandom_range(0, 1));
          endcase
          if (io_resp_yumi) begin
            last_resp = io_resp;
            last_yumi = cyc;
            void'(sb_q.pop_front());
            seen = 0;
          end
        end
      end else begin
        io_resp_yumi = 1'b0;
        seen = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached with %0d pending", sb_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0]      a;
    logic [2:0]       s;
    logic [3:0]       t;
    logic [MSG_W-1:0] held;
    int               r;

    reset_n  = 1'b0;
    io_cmd_v = 1'b0;
    io_cmd   = '0;
    for (int i = 0; i < NREGS*8; i++) mdl_mem[i] = 8'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", MSG_W'(io_cmd_ready), MSG_W'(0));
    chk("rst_resp_v", MSG_W'(io_resp_v), MSG_W'(0));
    chk("rst_resp", io_resp, '0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", MSG_W'(io_cmd_ready), MSG_W'(1));
    @(posedge clk);
    #1;

    // full-word write then read of reg1
    send(4'd3, BASE + 40'h8, 3'd3, 4'h5, 3'h1, {64'hFFFF_0000_FFFF_0000, 64'hDEAD_BEEF_0123_4567});
    drain();
    chk("wr_resp_data", last_resp[DATA_LSB +: BLK], '0);
    chk("wr_resp_type", MSG_W'(last_resp[3:0]), MSG_W'(4'd3));
    send(4'd2, BASE + 40'h8, 3'd3, 4'hA, 3'h2, rnd128());
    drain();
    chk("rd_reg1", last_resp[DATA_LSB +: BLK], MSG_W'(64'hDEAD_BEEF_0123_4567));
    chk("rd_lce_echo", MSG_W'(last_resp[LCE_LSB +: LCE_W]), MSG_W'(4'hA));

    // byte write into reg2
    send(4'd3, BASE + 40'h13, 3'd0, 4'h1, 3'h0, {120'h0, 8'hA5} | {rnd128()} & ~128'hFF);
    drain();
    send(4'd2, BASE + 40'h10, 3'd3, 4'h2, 3'h0, rnd128());
    drain();
    chk("rd_reg2_word", last_resp[DATA_LSB +: BLK], MSG_W'(64'h0000_0000_A500_0000));
    send(4'd2, BASE + 40'h13, 3'd0, 4'h3, 3'h0, rnd128());
    drain();
    chk("rd_reg2_byte", last_resp[DATA_LSB +: BLK], MSG_W'(64'hA5));

    // ID register is read-only; out-of-range read returns zero
    send(4'd3, BASE, 3'd3, 4'h4, 3'h0, 128'h1);
    drain();
    send(4'd2, BASE, 3'd3, 4'h4, 3'h0, rnd128());
    drain();
    chk("rd_id", last_resp[DATA_LSB +: BLK], MSG_W'(DEV_ID));
    send(4'd2, BASE + 40'h40, 3'd3, 4'h6, 3'h0, rnd128());
    drain();
    chk("rd_miss", last_resp[DATA_LSB +: BLK], '0);

    // misaligned write leaves reg1 untouched
    send(4'd3, BASE + 40'hA, 3'd2, 4'h7, 3'h0, {96'h0, 32'hFFFF_FFFF});
    drain();
    send(4'd2, BASE + 40'h8, 3'd3, 4'h7, 3'h0, rnd128());
    drain();
    chk("rd_reg1_after_misaligned", last_resp[DATA_LSB +: BLK], MSG_W'(64'hDEAD_BEEF_0123_4567));

    // backpressure: response held, next command waits for yumi
    yumi_mode = 2;
    send(4'd2, BASE + 40'h8, 3'd3, 4'h8, 3'h3, rnd128());
    held     = pack(4'd3, BASE + 40'h18, 3'd3, 4'h9, 3'h4, rnd128());
    io_cmd   = held;
    io_cmd_v = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_ready_low", MSG_W'(io_cmd_ready), MSG_W'(0));
      chk("bp_resp_v", MSG_W'(io_resp_v), MSG_W'(1));
    end
    @(posedge clk);
    #1;
    yumi_mode = 1;
    send(held[3:0], held[4 +: 40], held[44 +: 3], held[LCE_LSB +: LCE_W], held[47 +: 3],
         held[DATA_LSB +: BLK]);
    chk("bp_accept_after_yumi", MSG_W'(last_acc), MSG_W'(last_yumi + 1));
    drain();

    // randomized traffic
    yumi_mode = 0;
    for (int n = 0; n < 300; n++) begin
      s = 3'($urandom_range(0, 6));
      r = $urandom_range(0, 9);
      case (r)
        0:       a = {8'($urandom), 32'($urandom)};
        1:       a = BASE - 40'($urandom_range(1, 16));
        2:       a = BASE + 40'(8 * NREGS) + 40'($urandom_range(0, 16));
        default: a = BASE + 40'($urandom_range(0, 8 * NREGS - 1));
      endcase
      if ($urandom_range(0, 2) != 0) a = a & ~40'((s >= 3) ? 7 : ((1 << s) - 1));
      r = $urandom_range(0, 9);
      if (r < 4)       t = 4'd3;
      else if (r < 8)  t = 4'd2;
      else if (r == 8) t = 4'($urandom_range(0, 15));
      else             t = 4'($urandom_range(0, 1));
      send(t, a, s, 4'($urandom), 3'($urandom), rnd128());
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();

    // make reg1 nonzero, then reset while a response is pending
    yumi_mode = 1;
    send(4'd3, BASE + 40'h8, 3'd3, 4'h1, 3'h0, {64'h0, 64'h0BAD_F00D_CAFE_0001});
    drain();
    yumi_mode = 2;
    send(4'd2, BASE + 40'h8, 3'd3, 4'hB, 3'h5, rnd128());
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_resp_v", MSG_W'(io_resp_v), MSG_W'(0));
    chk("midrst_ready", MSG_W'(io_cmd_ready), MSG_W'(0));
    chk("midrst_resp", io_resp, '0);
    sb_q.delete();
    for (int i = 0; i < NREGS*8; i++) mdl_mem[i] = 8'h0;
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    yumi_mode = 0;
    send(4'd2, BASE + 40'h8, 3'd3, 4'hC, 3'h0, rnd128());
    drain();
    chk("rd_reg1_after_rst", last_resp[DATA_LSB +: BLK], '0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, fails);
    $finish;
  end

endmodule
